// File: rtl/gpi_debouncer.sv
// gpi_debouncer
//
// Conditions the board's switches and strap pins before they reach the
// system GPI port. Each pad is synchronised, polarity-corrected so that
// 1 always means "active", and debounced by its own stability counter.
// One-cycle rise/fall pulses mark accepted level changes. A strap snapshot
// is latched once every channel has been quiet for DebounceCycles cycles
// after reset, and it can be re-armed at any time.
//
// Ports
//   clk_sys_i      system clock (single domain)
//   rst_sys_ni     synchronous, active-low reset
//   raw_i          asynchronous pad inputs
//   strap_rearm_i  single-cycle request to re-capture the strap snapshot
//   level_o        debounced, polarity-corrected level
//   rise_o         one-cycle pulse on each 0->1 change of level_o
//   fall_o         one-cycle pulse on each 1->0 change of level_o
//   strap_o        latched snapshot of level_o
//   strap_valid_o  strap_o holds a settled capture
module gpi_debouncer #(
  parameter int unsigned      Width          = 13,
  parameter int unsigned      SyncStages     = 2,
  parameter int unsigned      DebounceCycles = 30000,
  parameter logic [Width-1:0] InvertMask     = {Width{1'b1}}
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_ni,
  input  logic [Width-1:0] raw_i,
  input  logic             strap_rearm_i,
  output logic [Width-1:0] level_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  output logic [Width-1:0] strap_o,
  output logic             strap_valid_o
);

  localparam int unsigned     CntW      = $clog2(DebounceCycles + 1);
  localparam int unsigned     PrimeW    = $clog2(SyncStages + 1);
  localparam logic [CntW-1:0] CntLast   = CntW'(DebounceCycles - 1);
  localparam logic [PrimeW-1:0] PrimeLast = PrimeW'(SyncStages - 1);

  // ---------------------------------------------------------------------------
  // Synchroniser. Stages reset to InvertMask so that an idle pull-up pad
  // (which reads high) looks inactive straight out of reset.
  // ---------------------------------------------------------------------------
  logic [SyncStages-1:0][Width-1:0] sync_reg;
  logic [Width-1:0]                 synced;

  always_ff @(posedge clk_sys_i) begin
    if (!rst_sys_ni) begin
      sync_reg <= {SyncStages{InvertMask}};
    end else begin
      sync_reg <= {sync_reg[SyncStages-2:0], raw_i};
    end
  end

  assign synced = sync_reg[SyncStages-1] ^ InvertMask;

  // ---------------------------------------------------------------------------
  // Per-channel debounce
  // ---------------------------------------------------------------------------
  logic [Width-1:0] level_reg, level_next;
  logic [Width-1:0] rise_reg, rise_next;
  logic [Width-1:0] fall_reg, fall_next;

  for (genvar gi = 0; gi < Width; gi++) begin : g_chan
    logic [CntW-1:0] cnt_reg;
    logic            differ;
    logic            expire;

    assign differ = synced[gi] ^ level_reg[gi];
    // The disagreement has now lasted DebounceCycles consecutive samples.
    assign expire = differ && (cnt_reg == CntLast);

    always_ff @(posedge clk_sys_i) begin
      if (!rst_sys_ni) begin
        cnt_reg <= '0;
      end else if (!differ || expire) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + CntW'(1);
      end
    end

    assign level_next[gi] = expire ? synced[gi] : level_reg[gi];
    assign rise_next[gi]  = expire &  synced[gi];
    assign fall_next[gi]  = expire & ~synced[gi];
  end

  always_ff @(posedge clk_sys_i) begin
    if (!rst_sys_ni) begin
      level_reg <= '0;
      rise_reg  <= '0;
      fall_reg  <= '0;
    end else begin
      level_reg <= level_next;
      rise_reg  <= rise_next;
      fall_reg  <= fall_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Strap capture. PRIME waits for the synchroniser to fill with real pad
  // values; SETTLE waits for DebounceCycles quiet cycles before latching.
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_PRIME,
    ST_SETTLE,
    ST_CAPTURED
  } state_e;

  state_e              state_reg, state_next;
  logic [PrimeW-1:0]   prime_reg, prime_next;
  logic [CntW-1:0]     quiet_reg, quiet_next;
  logic [Width-1:0]    strap_reg, strap_next;
  logic                valid_reg, valid_next;
  logic                quiet;

  assign quiet = (synced == level_reg);

  always_ff @(posedge clk_sys_i) begin
    if (!rst_sys_ni) begin
      state_reg <= ST_PRIME;
      prime_reg <= '0;
      quiet_reg <= '0;
      strap_reg <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      prime_reg <= prime_next;
      quiet_reg <= quiet_next;
      strap_reg <= strap_next;
      valid_reg <= valid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    prime_next = prime_reg;
    quiet_next = '0;          // cleared whenever we are not counting in SETTLE
    strap_next = strap_reg;
    valid_next = valid_reg;

    if (strap_rearm_i) begin
      // Re-arm overrides a capture that would happen this very cycle.
      state_next = ST_SETTLE;
      valid_next = 1'b0;
    end else begin
      case (state_reg)
        ST_PRIME: begin
          if (prime_reg == PrimeLast) begin
            state_next = ST_SETTLE;
            prime_next = '0;
          end else begin
            prime_next = prime_reg + PrimeW'(1);
          end
        end
        ST_SETTLE: begin
          if (!quiet) begin
            quiet_next = '0;
          end else if (quiet_reg == CntLast) begin
            strap_next = level_reg;
            valid_next = 1'b1;
            state_next = ST_CAPTURED;
          end else begin
            quiet_next = quiet_reg + CntW'(1);
          end
        end
        ST_CAPTURED: begin
          state_next = ST_CAPTURED;
        end
        default: begin
          state_next = ST_PRIME;
        end
      endcase
    end
  end

  assign level_o       = level_reg;
  assign rise_o        = rise_reg;
  assign fall_o        = fall_reg;
  assign strap_o       = strap_reg;
  assign strap_valid_o = valid_reg;

endmodule

// File: tb/tb_gpi_debouncer.sv
// tb_gpi_debouncer
//
// Drives directed scenarios followed by randomised pad activity. Every
// stimulus cycle pushes the reference model's expected outputs into a
// scoreboard queue; a separate monitor pops one entry per clock and compares.
// The reference model is a sliding-window description: a channel takes a new
// level once the last D synchronised samples since reset all disagree with
// it, and the strap is latched once the last D samples since entering the
// settle phase were all quiet.
module tb_gpi_debouncer;

  localparam int W = 4;
  localparam int S = 2;
  localparam int D = 8;
  localparam logic [W-1:0] INV = 4'b1111;

  logic         clk_sys_i;
  logic         rst_sys_ni;
  logic [W-1:0] raw_i;
  logic         strap_rearm_i;
  logic [W-1:0] level_o;
  logic [W-1:0] rise_o;
  logic [W-1:0] fall_o;
  logic [W-1:0] strap_o;
  logic         strap_valid_o;

  gpi_debouncer #(
    .Width          (W),
    .SyncStages     (S),
    .DebounceCycles (D),
    .InvertMask     (INV)
  ) dut (
    .clk_sys_i     (clk_sys_i),
    .rst_sys_ni    (rst_sys_ni),
    .raw_i         (raw_i),
    .strap_rearm_i (strap_rearm_i),
    .level_o       (level_o),
    .rise_o        (rise_o),
    .fall_o        (fall_o),
    .strap_o       (strap_o),
    .strap_valid_o (strap_valid_o)
  );

  initial clk_sys_i = 1'b0;
  always #5 clk_sys_i = ~clk_sys_i;

  typedef struct packed {
    logic [W-1:0] level;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] strap;
    logic         valid;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cycle    = 0;

  // Reference model state
  localparam int PH_PRIME = 0, PH_SETTLE = 1, PH_CAPT = 2;
  logic [W-1:0] m_level, m_strap;
  logic         m_valid;
  int           m_phase, m_since;
  logic [W-1:0] act_hist[$];   // active-high pad samples since reset
  logic [W-1:0] syn_hist[$];   // synchronised samples since reset
  bit           quiet_hist[$]; // quiet flags since entering settle

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Apply one cycle of inputs, predict the outputs after the next edge.
  task automatic step(input logic rst_n, input logic [W-1:0] raw, input logic rearm);
    exp_t         e;
    logic [W-1:0] act, syn, nlev;
    bit           all_diff, all_quiet, quiet;
    rst_sys_ni    = rst_n;
    raw_i         = raw;
    strap_rearm_i = rearm;
    if (!rst_n) begin
      m_level = '0; m_strap = '0; m_valid = 1'b0;
      m_phase = PH_PRIME; m_since = 0;
      act_hist.delete(); syn_hist.delete(); quiet_hist.delete();
      e = '0;
    end else begin
      act = raw ^ INV;
      // The synchroniser output lags the pad by S edges; before that it is idle.
      syn = (act_hist.size() >= S) ? act_hist[act_hist.size() - S] : '0;
      act_hist.push_back(act);
      if (act_hist.size() > 8) void'(act_hist.pop_front());
      syn_hist.push_back(syn);
      if (syn_hist.size() > 16) void'(syn_hist.pop_front());

      nlev = m_level;
      for (int b = 0; b < W; b++) begin
        if (syn_hist.size() >= D) begin
          all_diff = 1'b1;
          for (int j = 1; j <= D; j++)
            if (syn_hist[syn_hist.size() - j][b] == m_level[b]) all_diff = 1'b0;
          if (all_diff) nlev[b] = ~m_level[b];
        end
      end

      quiet = (syn == m_level);
      m_since++;
      if (rearm) begin
        m_valid = 1'b0;
        m_phase = PH_SETTLE;
        quiet_hist.delete();
      end else if (m_phase == PH_PRIME) begin
        if (m_since == S) m_phase = PH_SETTLE;
      end else if (m_phase == PH_SETTLE) begin
        quiet_hist.push_back(quiet);
        if (quiet_hist.size() > 16) void'(quiet_hist.pop_front());
        if (quiet_hist.size() >= D) begin
          all_quiet = 1'b1;
          for (int j = 1; j <= D; j++)
            if (!quiet_hist[quiet_hist.size() - j]) all_quiet = 1'b0;
          if (all_quiet) begin
            m_strap = m_level;
            m_valid = 1'b1;
            m_phase = PH_CAPT;
            quiet_hist.delete();
          end
        end
      end
      e.rise  = nlev & ~m_level;
      e.fall  = ~nlev & m_level;
      m_level = nlev;
      e.level = m_level;
      e.strap = m_strap;
      e.valid = m_valid;
    end
    sb.push_back(e);
    @(posedge clk_sys_i);
    #3;
  endtask

  // Monitor: one scoreboard entry per clock edge.
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk_sys_i);
      #1;
      cycle++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = {level_o, rise_o, fall_o, strap_o, strap_valid_o};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL sb cyc=%0d actual lvl=%h rise=%h fall=%h strap=%h valid=%b required lvl=%h rise=%h fall=%h strap=%h valid=%b",
                   cycle, a.level, a.rise, a.fall, a.strap, a.valid,
                   e.level, e.rise, e.fall, e.strap, e.valid);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] r;
    logic         rr, rn;
    rst_sys_ni    = 1'b0;
    raw_i         = 4'hF;
    strap_rearm_i = 1'b0;

    // 1: all inactive from reset
    step(0, 4'hF, 0); step(0, 4'hF, 0);
    for (int i = 1; i <= 12; i++) begin
      step(1, 4'hF, 0);
      if (i == 9)  chk("s1_valid_e9", strap_valid_o, 0);
      if (i == 10) chk("s1_valid_e10", strap_valid_o, 1);
      if (i == 10) chk("s1_strap_e10", strap_o, 4'h0);
    end
    $display("scenario idle_reset done cycle=%0d", cycle);

    // 2: channel 0 held active through reset
    step(0, 4'hE, 0); step(0, 4'hE, 0);
    for (int i = 1; i <= 20; i++) begin
      step(1, 4'hE, 0);
      if (i == 9)  chk("s2_level_e9", level_o, 4'h0);
      if (i == 10) chk("s2_level_e10", level_o, 4'h1);
      if (i == 10) chk("s2_rise_e10", rise_o, 4'h1);
      if (i == 11) chk("s2_rise_e11", rise_o, 4'h0);
      if (i == 17) chk("s2_valid_e17", strap_valid_o, 0);
      if (i == 18) chk("s2_valid_e18", strap_valid_o, 1);
      if (i == 18) chk("s2_strap_e18", strap_o, 4'h1);
    end
    $display("scenario held_active done cycle=%0d", cycle);

    // 3: bounce on channel 1
    for (int i = 0; i < 7; i++)  step(1, 4'hC, 0);
    for (int i = 0; i < 12; i++) step(1, 4'hE, 0);
    chk("s3_short_bounce", level_o, 4'h1);
    for (int i = 1; i <= 12; i++) begin
      step(1, 4'hC, 0);
      if (i == 9)  chk("s3_rise_early", rise_o, 4'h0);
      if (i == 10) chk("s3_rise", rise_o, 4'h2);
      if (i == 10) chk("s3_level_up", level_o, 4'h3);
    end
    for (int i = 1; i <= 12; i++) begin
      step(1, 4'hE, 0);
      if (i == 10) chk("s3_fall", fall_o, 4'h2);
      if (i == 10) chk("s3_level_dn", level_o, 4'h1);
    end
    $display("scenario bounce done cycle=%0d", cycle);

    // 4: rearm while channel 2 chatters
    step(1, 4'hE, 1);
    chk("s4_rearm_drop", strap_valid_o, 0);
    for (int i = 0; i < 30; i++) step(1, ((i / 3) % 2) ? 4'hA : 4'hE, 0);
    chk("s4_valid_while_chatter", strap_valid_o, 0);
    for (int i = 0; i < 30; i++) step(1, 4'hA, 0);
    chk("s4_valid_after", strap_valid_o, 1);
    chk("s4_strap_after", strap_o, 4'h5);
    $display("scenario rearm_chatter done cycle=%0d", cycle);

    // 5: rearm landing on the capture cycle
    step(1, 4'hA, 1);
    chk("s5_rearm0", strap_valid_o, 0);
    for (int i = 0; i < 7; i++) step(1, 4'hA, 0);
    step(1, 4'hA, 1);
    chk("s5_no_capture", strap_valid_o, 0);
    for (int i = 0; i < 7; i++) step(1, 4'hA, 0);
    chk("s5_valid_e7", strap_valid_o, 0);
    step(1, 4'hA, 0);
    chk("s5_valid_e8", strap_valid_o, 1);
    $display("scenario rearm_at_capture done cycle=%0d", cycle);

    // 6: reset in the middle of a debounce count
    for (int i = 0; i < 7; i++) step(1, 4'h2, 0);
    step(0, 4'h2, 0);
    chk("s6_reset_outputs", {level_o, rise_o, fall_o, strap_o, strap_valid_o}, '0);
    for (int i = 1; i <= 20; i++) begin
      step(1, 4'h2, 0);
      if (i == 9)  chk("s6_level_e9", level_o, 4'h0);
      if (i == 10) chk("s6_level_e10", level_o, 4'hD);
      if (i == 10) chk("s6_rise_e10", rise_o, 4'hD);
    end
    $display("scenario mid_reset done cycle=%0d", cycle);

    // 7: randomised activity
    r = 4'h2;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(4) == 0) r[$urandom_range(W - 1)] ^= 1'b1;
      rr = ($urandom_range(39) == 0);
      rn = ($urandom_range(299) != 0);
      step(rn, r, rr);
    end
    $display("scenario random done cycle=%0d", cycle);

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpi_debouncer.md
# gpi_debouncer

Parametrised general-purpose-input conditioner for Sonata board switches and strap pins. It synchronises N asynchronous pad inputs and corrects per-channel polarity for pull-up switches. Each channel is debounced with its own stability counter, and the block produces one-cycle rise/fall event pulses. After reset it latches a settled strap snapshot, for example the CHERI-enable DIP, and that snapshot can be re-armed. It sits between the top-level pads and the `sonata_system` GPI port.

## Interface
Parameters:
- `Width`, 13: number of input channels (>= 1).
- `SyncStages`, 2: synchroniser depth (>= 2).
- `DebounceCycles`, 30_000: consecutive stable cycles required to accept a new level (>= 1; 1 ms at 30 MHz).
- `InvertMask`, all ones: per-channel polarity; bit set means pad low = active.

Ports:
- `clk_sys_i`  in  1  system clock; single clock domain.
- `rst_sys_ni`  in  1  reset, synchronous, active-low.
- `raw_i`  in  Width  asynchronous pad inputs.
- `strap_rearm_i`  in  1  single-cycle request to discard and re-capture the strap snapshot.
- `level_o`  out  Width  debounced level, polarity-corrected (1 = active).
- `rise_o`  out  Width  one-cycle pulse on each 0->1 transition of `level_o`.
- `fall_o`  out  Width  one-cycle pulse on each 1->0 transition of `level_o`.
- `strap_o`  out  Width  latched snapshot of `level_o`.
- `strap_valid_o`  out  1  `strap_o` holds a settled capture.

## Operation
- Synchroniser:
  - `SyncStages` flops per channel; all stages reset to `InvertMask`.
  - `synced = last_stage ^ InvertMask`, so `synced` is 0 out of reset.
- Debounce, per channel:
  - Counter of width `$clog2(DebounceCycles+1)`.
  - `synced == level`: counter <= 0.
  - `synced != level` and counter == `DebounceCycles-1`: `level` <= `synced`, counter <= 0, and the matching `rise_o`/`fall_o` bit is set for that cycle.
  - Otherwise: counter increments.
  - A disagreement shorter than `DebounceCycles` cycles leaves `level` unchanged and restarts the count.
- Event pulses:
  - Registered and asserted in the same cycle `level_o` first shows the new value.
  - Never both set on one channel.
  - Deasserted on the following cycle.
- Strap capture:
  - States:
    - PRIME: counts `SyncStages` cycles after reset.
    - SETTLE: quiet counter active.
    - CAPTURED.
  - quiet = all channels have `synced == level`.
  - In SETTLE:
    - Not quiet: quiet counter <= 0.
    - Quiet and quiet counter == `DebounceCycles-1`: `strap_o` <= `level_o`, `strap_valid_o` <= 1, go to CAPTURED.
    - Otherwise quiet: quiet counter increments.
  - CAPTURED holds until reset or `strap_rearm_i`.
  - `strap_rearm_i` in any state: next state SETTLE, quiet counter <= 0, `strap_valid_o` <= 0. `strap_o` keeps its old value until the next capture.
  - Rearm and capture in the same cycle: rearm wins, no capture.
- Reset (any time, including mid-debounce):
  - Next edge sets `level_o`, `rise_o`, `fall_o`, `strap_o` and `strap_valid_o` to 0.
  - All counters clear; state goes to PRIME.

## Timing
- Reset deasserts at edge 0; S = `SyncStages`, D = `DebounceCycles`.
- Clean step on `raw_i`, present before edge k: `level_o` updates after edge k+S+D-1 (latency S+D edges). The event pulse is high for exactly that cycle.
- Channels held active through reset: `level_o` rises after edge S+D, producing a rise pulse. Any bench or software treating this as a real event must allow for it.
- Strap valid timing:
  - All inputs inactive and stable: `strap_valid_o` rises after edge S+D.
  - Any input held active: `strap_valid_o` rises after edge S+2D.
- Rearm sampled at edge r: `strap_valid_o` is low after edge r. With inputs quiet, it returns high after edge r+D.
- Counters never wrap; the quiet counter is cleared on leaving SETTLE.

## Test plan
Bench configuration: Width=4, S=2, D=8, InvertMask=4'b1111.
- Reset with `raw_i`=4'b1111 held -> `level_o`=0, no pulses ever, `strap_valid_o` high after edge 10 with `strap_o`=4'b0000.
- `raw_i`=4'b1110 held from reset -> `level_o`=4'b0001 and `rise_o`=4'b0001 after edge 10 (one cycle), `strap_valid_o` after edge 18, `strap_o`=4'b0001.
- Bounce tests on `raw_i[1]`:
  - Driven low for 7 cycles then high -> no change on any output.
  - Driven low for 8+ cycles -> `level_o[1]`=1 with a single `rise_o[1]` pulse 10 edges after the fall.
  - Released -> single `fall_o[1]` pulse 10 edges later.
- `strap_rearm_i` pulse while `raw_i[2]` toggles every 3 cycles -> `strap_valid_o` stays low. Toggling stops -> valid returns after level settles plus 8 quiet edges, `strap_o` updated.
- Rearm asserted in exactly the capture cycle -> no capture. `strap_valid_o` rises 8 edges later.
- `rst_sys_ni` low for one cycle while a debounce counter = 5 -> all outputs 0 after that edge. Full S+D latency is required again for every channel.
